matrix_op_conv_gen: RTL and testbench

Parametrised 2-D convolution engine for the matrix calculator. It generalises the fixed 3x3 valid-only engine with a runtime kernel size from 1 to MAX_K, valid or zero-padded "same" output, stride 1..3, and signed/unsigned arithmetic with optional saturation. It sits on the shared single-port BRAM read/write interface under the calculator controller. Kernel taps are cached in registers once per operation, and padding taps cost no memory reads.

---
 rtl/matrix_op_conv_gen_if.sv | 43 ++++
 rtl/matrix_op_conv_gen.sv | 250 +++++++++++++++++++++++++
 tb/tb_matrix_op_conv_gen.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_op_conv_gen_if.sv
// rtl/matrix_op_conv_gen_if.sv - control, configuration and BRAM port bundle for the convolution engine
interface matrix_op_conv_gen_if #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 10
);
  logic                     start;
  logic                     done;
  logic                     busy;
  logic                     err;
  logic [4:0]               dim_m;
  logic [4:0]               dim_n;
  logic [2:0]               k_dim;
  logic                     pad_mode;
  logic [1:0]               stride;
  logic                     signed_en;
  logic                     sat_en;
  logic [ADDR_WIDTH-1:0]    addr_op1;
  logic [ADDR_WIDTH-1:0]    addr_op2;
  logic [ADDR_WIDTH-1:0]    addr_res;
  logic                     mem_rd_en;
  logic [ADDR_WIDTH-1:0]    mem_rd_addr;
  logic [ELEMENT_WIDTH-1:0] mem_rd_data;
  logic                     mem_wr_en;
  logic [ADDR_WIDTH-1:0]    mem_wr_addr;
  logic [ELEMENT_WIDTH-1:0] mem_wr_data;
  logic [4:0]               out_rows;
  logic [4:0]               out_cols;
  logic [12:0]              clock_cyc;

  modport slave (
    input  start, dim_m, dim_n, k_dim, pad_mode, stride, signed_en, sat_en,
           addr_op1, addr_op2, addr_res, mem_rd_data,
    output done, busy, err, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
           mem_wr_data, out_rows, out_cols, clock_cyc
  );

  modport master (
    output start, dim_m, dim_n, k_dim, pad_mode, stride, signed_en, sat_en,
           addr_op1, addr_op2, addr_res, mem_rd_data,
    input  done, busy, err, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
           mem_wr_data, out_rows, out_cols, clock_cyc
  );
endinterface

// File: rtl/matrix_op_conv_gen.sv
// rtl/matrix_op_conv_gen.sv - runtime-configurable 2-D convolution over a shared single-port BRAM
module matrix_op_conv_gen #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 10,
  parameter int MAX_K         = 5,
  parameter int ACC_WIDTH     = 24
) (
  input logic                 clk,
  input logic                 rst,
  matrix_op_conv_gen_if.slave bus
);
  localparam int EW = ELEMENT_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int NT = MAX_K * MAX_K;
  localparam int TW = $clog2(NT + 1);
  localparam logic [ACC_WIDTH-1:0]        U_MAX = ACC_WIDTH'((1 << EW) - 1);
  localparam logic signed [ACC_WIDTH-1:0] S_MAX = ACC_WIDTH'((1 << (EW - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] S_MIN = ACC_WIDTH'(-(1 << (EW - 1)));

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_KRD, S_KWAIT, S_KCAP, S_PIX, S_TAP, S_AWAIT, S_MAC, S_WR, S_NXT, S_DONE
  } state_t;

  typedef struct packed {
    logic [4:0]    dim_m;
    logic [4:0]    dim_n;
    logic [2:0]    k;
    logic          pad;
    logic [1:0]    stride;
    logic          sgn;
    logic          sat;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [AW-1:0] ar;
  } cfg_t;

  state_t                state_q, state_d;
  cfg_t                  cfg_q, cfg_d;
  logic                  err_q, err_d;
  logic [4:0]            out_rows_q, out_rows_d, out_cols_q, out_cols_d;
  logic [4:0]            r_q, r_d, c_q, c_d;
  logic [2:0]            ki_q, ki_d, kj_q, kj_d;
  logic [TW-1:0]         t_q, t_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [12:0]           cyc_q, cyc_d, clock_cyc_q, clock_cyc_d;
  logic [EW-1:0]         taps_q [NT];
  logic [EW-1:0]         taps_d [NT];

  logic                  busy_w, rd_img, in_range, last_tap, cfg_bad, advance;
  logic [5:0]            kk;
  logic [2:0]            pad_p;
  logic [6:0]            org_r, org_c, y, x;
  logic [AW-1:0]         img_addr;
  logic [4:0]            rows_calc, cols_calc;
  logic [ACC_WIDTH-1:0]  prod;
  logic [EW-1:0]         result;

  function automatic logic [4:0] div_stride(input logic [4:0] v, input logic [1:0] s);
    case (s)
      2'd2:    return v >> 1;
      2'd3:    return v / 5'd3;
      default: return v;
    endcase
  endfunction

  function automatic logic [ACC_WIDTH-1:0] ext(input logic [EW-1:0] v, input logic s);
    return {{(ACC_WIDTH - EW){s & v[EW-1]}}, v};
  endfunction

  // Window origin is signed so that "same" padding can start above/left of the image.
  assign kk       = 6'(cfg_q.k) * 6'(cfg_q.k);
  assign last_tap = (6'(t_q) == kk - 6'd1);
  assign pad_p    = cfg_q.pad ? ((cfg_q.k - 3'd1) >> 1) : 3'd0;
  assign org_r    = 7'(r_q) * 7'(cfg_q.stride) - 7'(pad_p);
  assign org_c    = 7'(c_q) * 7'(cfg_q.stride) - 7'(pad_p);
  assign y        = org_r + 7'(ki_q);
  assign x        = org_c + 7'(kj_q);
  assign in_range = !y[6] && !x[6] && (y < 7'(cfg_q.dim_m)) && (x < 7'(cfg_q.dim_n));
  assign img_addr = cfg_q.a1 + AW'(y) * AW'(cfg_q.dim_n) + AW'(x);
  assign prod     = ext(bus.mem_rd_data, cfg_q.sgn) * ext(taps_q[t_q], cfg_q.sgn);

  assign cfg_bad = (cfg_q.k == 3'd0) || (32'(cfg_q.k) > MAX_K) || (cfg_q.stride == 2'd0) ||
                   (cfg_q.pad && !cfg_q.k[0]) ||
                   (!cfg_q.pad && ((5'(cfg_q.k) > cfg_q.dim_m) || (5'(cfg_q.k) > cfg_q.dim_n))) ||
                   (cfg_q.dim_m == 5'd0) || (cfg_q.dim_n == 5'd0);

  assign rows_calc = cfg_q.pad ? div_stride(cfg_q.dim_m + 5'(cfg_q.stride) - 5'd1, cfg_q.stride)
                               : div_stride(cfg_q.dim_m - 5'(cfg_q.k), cfg_q.stride) + 5'd1;
  assign cols_calc = cfg_q.pad ? div_stride(cfg_q.dim_n + 5'(cfg_q.stride) - 5'd1, cfg_q.stride)
                               : div_stride(cfg_q.dim_n - 5'(cfg_q.k), cfg_q.stride) + 5'd1;

  // Reduce the accumulator to one element, clamping or wrapping as configured
  always_comb begin
    result = acc_q[EW-1:0];
    if (cfg_q.sat) begin
      if (cfg_q.sgn) begin
        if ($signed(acc_q) > S_MAX)      result = S_MAX[EW-1:0];
        else if ($signed(acc_q) < S_MIN) result = S_MIN[EW-1:0];
      end else if (acc_q > U_MAX) begin
        result = U_MAX[EW-1:0];
      end
    end
  end

  // Sequencer: config check, kernel caching, per-output tap walk, write-back
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    err_d       = err_q;
    out_rows_d  = out_rows_q;
    out_cols_d  = out_cols_q;
    r_d         = r_q;
    c_d         = c_q;
    ki_d        = ki_q;
    kj_d        = kj_q;
    t_d         = t_q;
    acc_d       = acc_q;
    cyc_d       = cyc_q;
    clock_cyc_d = clock_cyc_q;
    taps_d      = taps_q;
    advance     = 1'b0;
    if (busy_w) cyc_d = cyc_q + 13'd1;
    case (state_q)
      S_IDLE: if (bus.start) begin
        cfg_d = '{dim_m: bus.dim_m, dim_n: bus.dim_n, k: bus.k_dim, pad: bus.pad_mode,
                  stride: bus.stride, sgn: bus.signed_en, sat: bus.sat_en,
                  a1: bus.addr_op1, a2: bus.addr_op2, ar: bus.addr_res};
        cyc_d   = '0;
        state_d = S_CHECK;
      end
      S_CHECK: if (cfg_bad) begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end else begin
        out_rows_d = rows_calc;
        out_cols_d = cols_calc;
        t_d        = '0;
        state_d    = S_KRD;
      end
      S_KRD:   state_d = S_KWAIT;
      S_KWAIT: state_d = S_KCAP;
      S_KCAP: begin
        taps_d[t_q] = bus.mem_rd_data;
        if (last_tap) begin
          r_d     = '0;
          c_d     = '0;
          state_d = S_PIX;
        end else begin
          t_d     = t_q + 1'b1;
          state_d = S_KRD;
        end
      end
      S_PIX: begin
        acc_d   = '0;
        ki_d    = '0;
        kj_d    = '0;
        t_d     = '0;
        state_d = S_TAP;
      end
      // Padding taps contribute zero and skip the memory round trip entirely
      S_TAP: if (in_range) begin
        state_d = S_AWAIT;
      end else begin
        advance = 1'b1;
        state_d = last_tap ? S_WR : S_TAP;
      end
      S_AWAIT: state_d = S_MAC;
      S_MAC: begin
        acc_d   = acc_q + prod;
        advance = 1'b1;
        state_d = last_tap ? S_WR : S_TAP;
      end
      S_WR: state_d = S_NXT;
      S_NXT: begin
        state_d = S_PIX;
        if (c_q == out_cols_q - 5'd1) begin
          c_d = '0;
          if (r_q == out_rows_q - 5'd1) state_d = S_DONE;
          else                          r_d = r_q + 5'd1;
        end else begin
          c_d = c_q + 5'd1;
        end
      end
      S_DONE: if (!bus.start) begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      t_d = t_q + 1'b1;
      if (kj_q == cfg_q.k - 3'd1) begin
        kj_d = '0;
        ki_d = ki_q + 3'd1;
      end else begin
        kj_d = kj_q + 3'd1;
      end
    end
    if (state_d == S_DONE && state_q != S_DONE) clock_cyc_d = cyc_d;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      err_q       <= 1'b0;
      out_rows_q  <= '0;
      out_cols_q  <= '0;
      r_q         <= '0;
      c_q         <= '0;
      ki_q        <= '0;
      kj_q        <= '0;
      t_q         <= '0;
      acc_q       <= '0;
      cyc_q       <= '0;
      clock_cyc_q <= '0;
      taps_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      err_q       <= err_d;
      out_rows_q  <= out_rows_d;
      out_cols_q  <= out_cols_d;
      r_q         <= r_d;
      c_q         <= c_d;
      ki_q        <= ki_d;
      kj_q        <= kj_d;
      t_q         <= t_d;
      acc_q       <= acc_d;
      cyc_q       <= cyc_d;
      clock_cyc_q <= clock_cyc_d;
      taps_q      <= taps_d;
    end
  end

  assign busy_w          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign rd_img          = (state_q == S_TAP) && in_range;
  assign bus.busy        = busy_w;
  assign bus.done        = (state_q == S_DONE);
  assign bus.err         = err_q;
  assign bus.mem_rd_en   = (state_q == S_KRD) || rd_img;
  assign bus.mem_rd_addr = (state_q == S_KRD) ? cfg_q.a2 + AW'(t_q) : (rd_img ? img_addr : '0);
  assign bus.mem_wr_en   = (state_q == S_WR);
  assign bus.mem_wr_addr = (state_q == S_WR) ? cfg_q.ar + AW'(r_q) * AW'(out_cols_q) + AW'(c_q) : '0;
  assign bus.mem_wr_data = (state_q == S_WR) ? result : '0;
  assign bus.out_rows    = out_rows_q;
  assign bus.out_cols    = out_cols_q;
  assign bus.clock_cyc   = clock_cyc_q;
endmodule

// File: tb/tb_matrix_op_conv_gen.sv
// tb/tb_matrix_op_conv_gen.sv - directed self-checking bench for matrix_op_conv_gen
module tb_matrix_op_conv_gen;
  localparam int EW = 8;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_op_conv_gen_if #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW)) bus ();
  matrix_op_conv_gen #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .MAX_K(5), .ACC_WIDTH(24)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]    img [1024];
  logic [AW-1:0] wl_addr [512];
  logic [7:0]    wl_data [512];
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  int            both_cnt = 0;
  logic          p1_v = 1'b0, p2_v = 1'b0;
  logic [AW-1:0] p1_a = '0, p2_a = '0;

  // BRAM model: address taken mid-cycle, data presented two cycles later
  always @(negedge clk) begin
    if (bus.mem_rd_en && bus.mem_wr_en) both_cnt = both_cnt + 1;
    if (bus.mem_rd_en) rd_cnt = rd_cnt + 1;
    if (bus.mem_wr_en) begin
      wl_addr[wr_cnt % 512] = bus.mem_wr_addr;
      wl_data[wr_cnt % 512] = bus.mem_wr_data;
      wr_cnt = wr_cnt + 1;
    end
    if (p2_v) bus.mem_rd_data = img[p2_a];
    p2_v = p1_v;
    p2_a = p1_a;
    p1_v = bus.mem_rd_en;
    p1_a = bus.mem_rd_addr;
  end

  task automatic fill_seq(input int base, input int len);
    for (int i = 0; i < len; i++) img[base + i] = 8'(i + 1);
  endtask

  task automatic fill_const(input int base, input int len, input logic [7:0] v);
    for (int i = 0; i < len; i++) img[base + i] = v;
  endtask

  task automatic apply_cfg(input logic [4:0] m, input logic [4:0] n, input logic [2:0] k,
                           input logic pad, input logic [1:0] s, input logic sg, input logic sat,
                           input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] ar);
    bus.dim_m = m; bus.dim_n = n; bus.k_dim = k; bus.pad_mode = pad; bus.stride = s;
    bus.signed_en = sg; bus.sat_en = sat;
    bus.addr_op1 = a1; bus.addr_op2 = a2; bus.addr_res = ar;
    bus.start = 1'b1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.done) ok = 1'b1;
    end
  endtask

  task automatic drop_start();
    bus.start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.done, bus.busy, bus.err, bus.mem_rd_en, bus.mem_wr_en} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 00000", {bus.done, bus.busy, bus.err, bus.mem_rd_en, bus.mem_wr_en});
    end
    checks++;
    if ({bus.out_rows, bus.out_cols, bus.clock_cyc} !== 23'd0) begin
      failures++;
      $display("FAIL reset_regs: got rows %0d cols %0d cyc %0d expected 0 0 0", bus.out_rows, bus.out_cols, bus.clock_cyc);
    end
  endtask

  task automatic test_valid();
    bit ok;
    int rd0, wr0, bc0;
    logic [7:0] exp_v [4] = '{8'd54, 8'd63, 8'd90, 8'd99};
    fill_seq(0, 16);
    fill_const(100, 9, 8'd1);
    rd0 = rd_cnt; wr0 = wr_cnt; bc0 = both_cnt;
    apply_cfg(5'd4, 5'd4, 3'd3, 1'b0, 2'd1, 1'b0, 1'b0, 10'd0, 10'd100, 10'd200);
    wait_done(ok);
    checks++;
    if (!ok || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL valid_done: got done %0b err %0b busy %0b expected 1 0 0", ok, bus.err, bus.busy);
    end
    checks++;
    if (bus.out_rows !== 5'd2 || bus.out_cols !== 5'd2) begin
      failures++;
      $display("FAIL valid_dims: got %0dx%0d expected 2x2", bus.out_rows, bus.out_cols);
    end
    checks++;
    if (wr_cnt - wr0 != 4 || rd_cnt - rd0 != 45 || both_cnt != bc0) begin
      failures++;
      $display("FAIL valid_strobes: got wr %0d rd %0d both %0d expected 4 45 0", wr_cnt - wr0, rd_cnt - rd0, both_cnt - bc0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wl_addr[(wr0 + i) % 512] !== AW'(200 + i) || wl_data[(wr0 + i) % 512] !== exp_v[i]) begin
        failures++;
        $display("FAIL valid_wr%0d: got addr %0d data %0d expected addr %0d data %0d", i,
                 wl_addr[(wr0 + i) % 512], wl_data[(wr0 + i) % 512], 200 + i, exp_v[i]);
      end
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (bus.done !== 1'b1 || wr_cnt - wr0 != 4) begin
      failures++;
      $display("FAIL valid_hold: got done %0b writes %0d expected 1 4", bus.done, wr_cnt - wr0);
    end
    drop_start();
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL valid_exit: got done %0b expected 0", bus.done);
    end
  endtask

  task automatic test_same();
    bit ok;
    int rd0, wr0;
    logic [7:0] exp_v [9] = '{8'd4, 8'd6, 8'd4, 8'd6, 8'd9, 8'd6, 8'd4, 8'd6, 8'd4};
    fill_const(0, 9, 8'd1);
    fill_const(100, 9, 8'd1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    apply_cfg(5'd3, 5'd3, 3'd3, 1'b1, 2'd1, 1'b0, 1'b0, 10'd0, 10'd100, 10'd300);
    wait_done(ok);
    checks++;
    if (!ok || bus.err !== 1'b0 || bus.out_rows !== 5'd3 || bus.out_cols !== 5'd3) begin
      failures++;
      $display("FAIL same_done: got done %0b err %0b dims %0dx%0d expected 1 0 3x3", ok, bus.err, bus.out_rows, bus.out_cols);
    end
    checks++;
    if (rd_cnt - rd0 != 58 || wr_cnt - wr0 != 9) begin
      failures++;
      $display("FAIL same_strobes: got rd %0d wr %0d expected 58 9", rd_cnt - rd0, wr_cnt - wr0);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (wl_addr[(wr0 + i) % 512] !== AW'(300 + i) || wl_data[(wr0 + i) % 512] !== exp_v[i]) begin
        failures++;
        $display("FAIL same_wr%0d: got addr %0d data %0d expected addr %0d data %0d", i,
                 wl_addr[(wr0 + i) % 512], wl_data[(wr0 + i) % 512], 300 + i, exp_v[i]);
      end
    end
    drop_start();
  endtask

  task automatic test_saturation();
    bit ok;
    int wr0;
    logic [7:0] pix [4] = '{8'd100, 8'd100, 8'h9C, 8'h9C};
    logic       sg  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       sat [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_v [4] = '{8'd132, 8'd255, 8'h80, 8'h7C};
    fill_const(100, 9, 8'd1);
    for (int v = 0; v < 4; v++) begin
      fill_const(0, 9, pix[v]);
      wr0 = wr_cnt;
      apply_cfg(5'd3, 5'd3, 3'd3, 1'b0, 2'd1, sg[v], sat[v], 10'd0, 10'd100, 10'd400);
      wait_done(ok);
      checks++;
      if (!ok || wr_cnt - wr0 != 1 || wl_data[wr0 % 512] !== exp_v[v]) begin
        failures++;
        $display("FAIL sat_case%0d: got done %0b writes %0d data %0d expected 1 1 %0d", v, ok, wr_cnt - wr0, wl_data[wr0 % 512], exp_v[v]);
      end
      drop_start();
    end
  endtask

  task automatic test_stride2();
    bit ok;
    int wr0;
    logic [7:0] exp_v [4] = '{8'd7, 8'd13, 8'd37, 8'd43};
    fill_seq(0, 25);
    fill_const(100, 9, 8'd0);
    img[100] = 8'd1;
    img[102] = 8'd2;
    wr0 = wr_cnt;
    apply_cfg(5'd5, 5'd5, 3'd3, 1'b0, 2'd2, 1'b0, 1'b0, 10'd0, 10'd100, 10'd500);
    wait_done(ok);
    checks++;
    if (!ok || bus.out_rows !== 5'd2 || bus.out_cols !== 5'd2 || wr_cnt - wr0 != 4) begin
      failures++;
      $display("FAIL stride2_dims: got done %0b dims %0dx%0d writes %0d expected 1 2x2 4", ok, bus.out_rows, bus.out_cols, wr_cnt - wr0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wl_addr[(wr0 + i) % 512] !== AW'(500 + i) || wl_data[(wr0 + i) % 512] !== exp_v[i]) begin
        failures++;
        $display("FAIL stride2_wr%0d: got addr %0d data %0d expected addr %0d data %0d", i,
                 wl_addr[(wr0 + i) % 512], wl_data[(wr0 + i) % 512], 500 + i, exp_v[i]);
      end
    end
    drop_start();
  endtask

  task automatic test_errors();
    bit ok;
    int rd0, wr0;
    logic [4:0] m [3] = '{5'd5, 5'd3, 5'd4};
    logic [2:0] k [3] = '{3'd4, 3'd5, 3'd3};
    logic       p [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0] s [3] = '{2'd1, 2'd1, 2'd0};
    for (int e = 0; e < 3; e++) begin
      rd0 = rd_cnt; wr0 = wr_cnt;
      apply_cfg(m[e], m[e], k[e], p[e], s[e], 1'b0, 1'b0, 10'd0, 10'd100, 10'd600);
      wait_done(ok);
      checks++;
      if (!ok || bus.err !== 1'b1 || rd_cnt != rd0 || wr_cnt != wr0) begin
        failures++;
        $display("FAIL err_case%0d: got done %0b err %0b rd %0d wr %0d expected 1 1 0 0", e, ok, bus.err, rd_cnt - rd0, wr_cnt - wr0);
      end
      checks++;
      if (bus.clock_cyc !== 13'd1) begin
        failures++;
        $display("FAIL err_cyc%0d: got %0d expected 1", e, bus.clock_cyc);
      end
      drop_start();
      checks++;
      if (bus.err !== 1'b0 || bus.done !== 1'b0) begin
        failures++;
        $display("FAIL err_clear%0d: got err %0b done %0b expected 0 0", e, bus.err, bus.done);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen, rd0, wr0;
    logic [7:0] exp_v [4] = '{8'd54, 8'd63, 8'd90, 8'd99};
    fill_seq(0, 16);
    fill_const(100, 9, 8'd1);
    apply_cfg(5'd4, 5'd4, 3'd3, 1'b0, 2'd1, 1'b0, 1'b0, 10'd0, 10'd100, 10'd700);
    seen = 0;
    for (int i = 0; i < 500 && seen < 11; i++) begin
      @(posedge clk); #1;
      if (bus.mem_rd_en) seen++;
    end
    checks++;
    if (seen != 11) begin
      failures++;
      $display("FAIL rstmid_reach: got %0d reads expected 11", seen);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    wr0 = wr_cnt;
    @(posedge clk); #1;
    checks++;
    if ({bus.done, bus.busy, bus.err, bus.mem_rd_en, bus.mem_wr_en, bus.mem_rd_addr, bus.mem_wr_addr,
         bus.mem_wr_data, bus.out_rows, bus.out_cols, bus.clock_cyc} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs: got busy %0b rows %0d cols %0d rd_addr %0d expected all 0", bus.busy, bus.out_rows, bus.out_cols, bus.mem_rd_addr);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    rd0 = rd_cnt;
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (wr_cnt != wr0 || rd_cnt != rd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_quiet: got wr %0d rd %0d busy %0b expected 0 0 0", wr_cnt - wr0, rd_cnt - rd0, bus.busy);
    end
    wr0 = wr_cnt;
    apply_cfg(5'd4, 5'd4, 3'd3, 1'b0, 2'd1, 1'b0, 1'b0, 10'd0, 10'd100, 10'd700);
    wait_done(ok);
    checks++;
    if (!ok || wr_cnt - wr0 != 4) begin
      failures++;
      $display("FAIL rstmid_rerun: got done %0b writes %0d expected 1 4", ok, wr_cnt - wr0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wl_addr[(wr0 + i) % 512] !== AW'(700 + i) || wl_data[(wr0 + i) % 512] !== exp_v[i]) begin
        failures++;
        $display("FAIL rstmid_wr%0d: got addr %0d data %0d expected addr %0d data %0d", i,
                 wl_addr[(wr0 + i) % 512], wl_data[(wr0 + i) % 512], 700 + i, exp_v[i]);
      end
    end
    drop_start();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) img[i] = 8'd0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.mem_rd_data = '0;
    apply_cfg(5'd0, 5'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_valid();
    test_same();
    test_saturation();
    test_stride2();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
